uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, giving the number of CLK cycles per serial bit (legal range 2 to 255).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of 8-bit entries in the transmit FIFO (legal values: a power of 2, at least 2).
REQ-003 Port CLK, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset; synchronous, active-high; clock CLK.
REQ-005 Port wr_en, input, 1 bit: write strobe from the CPU OI control line; sampled every cycle.
REQ-006 Port din, input, 8 bits: byte to transmit (the bus value); sampled when wr_en=1.
REQ-007 Port full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-008 Port busy, output, 1 bit: FIFO is non-empty or a frame is in progress; the CPU uses it to stall OUT.
REQ-009 Port count, output, log2(FIFO_DEPTH)+1 bits: number of FIFO entries.
REQ-010 Port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-011 Port tx_done, output, 1 bit: one-cycle pulse on the last cycle of each stop bit.
REQ-012 Port tx, output, 1 bit: registered serial line; idle high.

Function
REQ-013 Write accept: at the clock edge, a write SHALL be accepted when wr_en=1 and full=0 (full as it was before the edge), appending din at the FIFO tail.
REQ-014 Write while full: a write with wr_en=1 and full=1 SHALL be discarded and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-015 Pop: a pop SHALL occur only in state IDLE with count>0 before the edge; an accept into an empty FIFO is popped on the following cycle.
REQ-016 Simultaneous accept and pop SHALL leave count unchanged.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; output ordering SHALL be first-in, first-out.
REQ-018 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-019 IDLE: tx=1; on a pop, the FSM SHALL load the byte into the shift register, clear the bit timer, and go to START.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-021 DATA: tx SHALL equal the data bit, LSB first, for CLKS_PER_BIT cycles per bit across 8 bits, then go to STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 on the final cycle; then go to IDLE.
REQ-023 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles with tx low at start; consecutive frames SHALL be separated by exactly one IDLE cycle (tx=1).
REQ-024 Latency: tx SHALL fall on the second cycle after an accepted write into an empty, idle block (accept edge, then pop edge).
REQ-025 tx SHALL be driven from a flop and SHALL never glitch or show X after reset.
REQ-026 busy SHALL be combinational from count and state, with busy = (count != 0) or (state != IDLE).
REQ-027 overflow SHALL clear only on rst.

Reset
REQ-028 With rst=1 at an edge, the block SHALL set state=IDLE, tx=1, count=0, full=0, busy=0, overflow=0, tx_done=0, and clear FIFO pointers, shift register and bit timer.
REQ-029 Reset mid-frame SHALL abort the frame, returning tx=1 from the next cycle; buffered bytes are lost.
REQ-030 rst SHALL take priority over wr_en in the same cycle, so the write is not accepted.

Verification
REQ-031 Single byte, CLKS_PER_BIT=4: write 0xA5 at cycle 0 -> tx low during cycles 2-5, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high cycles 38-41, tx_done pulse at cycle 41, busy low from cycle 42.
REQ-032 Burst: write 0x01-0x06 on cycles 0-5 -> 0x01-0x05 accepted, count reaches 4 at cycle 4, full=1, 0x06 dropped, overflow=1; serial output is 0x01..0x05 in order with 1-cycle gaps.
REQ-033 Program output: write 0x15 -> LSB-first data bits 1,0,1,0,1,0,0,0; count returns to 0 after the pop; tx_done asserts exactly once.
REQ-034 Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued -> tx=1, count=0, busy=0 the next cycle, and no tx_done.
REQ-035 Simultaneous full-write and pop: count=4, IDLE, wr_en=1 -> write dropped, count=3, overflow=1.
REQ-036 Reset versus write: rst and wr_en high in the same cycle -> count=0 afterward, and tx stays high.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO: 8N1 frames, LSB first, idle-high line.
// A pop happens only from IDLE, so back-to-back frames are separated by one idle cycle.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit, line low
// DATA  | eight data bits, LSB first
// STOP  | stop bit, line high; tx_done on its last cycle
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    din,
    output logic                          full,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          tx_done,
    output logic                          tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [7:0]    r_shift;
    logic [7:0]    r_timer;
    logic [2:0]    r_bit_idx;
    logic          r_tx;
    logic          r_overflow;

    logic w_full;
    logic w_accept;
    logic w_pop;
    logic w_bit_end;

    assign w_full    = (r_count == CNT_FULL);
    assign w_accept  = wr_en && !w_full;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_bit_end = (r_timer == BIT_LAST);

    assign full     = w_full;
    assign count    = r_count;
    assign busy     = (r_count != '0) || (r_state != S_IDLE);
    assign overflow = r_overflow;
    assign tx       = r_tx;
    assign tx_done  = (r_state == S_STOP) && w_bit_end;

    // Storage carries no reset; only the pointers and count define its contents.
    always_ff @(posedge CLK) begin
        if (!rst && w_accept) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_timer <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // Line always shows r_shift[0]; shift to expose the next bit.
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
